// File: rtl/chord_suggest_seq.sv
// Melody-note chord suggester: scans up to four diatonic chords that contain the
// latched note and filters them through a writable degree-transition table.
module chord_suggest_seq #(
    parameter int NUM_CAND    = 4,
    parameter int CHORD_NOTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    recalculate,
    input  logic [3:0]              key,
    input  logic [3:0]              note,
    input  logic                    sel_valid,
    input  logic [2:0]              sel_deg,
    input  logic                    tbl_we,
    input  logic [2:0]              tbl_addr,
    input  logic [7:0]              tbl_data,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [16*NUM_CAND-1:0]  chords,
    output logic [NUM_CAND-1:0]     cand_mask,
    output logic                    busy,
    output logic [2:0]              cur_deg
);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_next;
    logic [1:0]  idx_p0;
    logic [3:0]  key_p0;
    logic [2:0]  deg_p0;
    logic [2:0]  from_p0;
    logic [7:0]  tbl [8];
    logic [4:0]  diff;
    logic [2:0]  cand_deg;
    logic        cand_ok;
    logic [15:0] cand_slot;

    // Operands are always below 24, so one conditional subtract is enough.
    function automatic logic [3:0] wrap12(input logic [4:0] v);
        return (v >= 5'd12) ? 4'(v - 5'd12) : v[3:0];
    endfunction

    function automatic logic [2:0] interval_degree(input logic [3:0] iv);
        case (iv)
            4'd0:    return 3'd1;
            4'd2:    return 3'd2;
            4'd4:    return 3'd3;
            4'd5:    return 3'd4;
            4'd7:    return 3'd5;
            4'd9:    return 3'd6;
            4'd11:   return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] scale_offset(input logic [2:0] deg);
        case (deg)
            3'd2:    return 4'd2;
            3'd3:    return 4'd4;
            3'd4:    return 4'd5;
            3'd5:    return 4'd7;
            3'd6:    return 4'd9;
            3'd7:    return 4'd11;
            default: return 4'd0;
        endcase
    endfunction

    // Moves a 1-based degree up by 'up' scale steps (up <= 14), wrapping 7 -> 1.
    function automatic logic [2:0] step_degree(input logic [2:0] base, input logic [3:0] up);
        logic [4:0] s;
        s = {2'b00, base} - 5'd1 + {1'b0, up};
        if (s >= 5'd14)
            s = s - 5'd14;
        else if (s >= 5'd7)
            s = s - 5'd7;
        return s[2:0] + 3'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (recalculate) state_next = SCAN;
            SCAN:    if (idx_p0 == 2'(NUM_CAND - 1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            SCAN: busy = 1'b1;
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign diff = {1'b0, note} + 5'd12 - {1'b0, key};

    // Candidate k has the melody note as its root, third, fifth, seventh: 2k steps down.
    always_comb begin
        cand_deg  = step_degree(deg_p0, 4'd14 - {1'b0, idx_p0, 1'b0});
        cand_ok   = (deg_p0 != 3'd0) && tbl[from_p0][cand_deg];
        cand_slot = '1;
        if (cand_ok) begin
            for (int j = 0; j < 4; j++) begin
                if (j < CHORD_NOTES)
                    cand_slot[4*(3-j) +: 4] = wrap12({1'b0, key_p0}
                        + {1'b0, scale_offset(step_degree(cand_deg, 4'(2*j)))});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chords    <= '1;
            cand_mask <= '0;
            cur_deg   <= 3'd1;
            idx_p0    <= 2'd0;
            key_p0    <= 4'd0;
            deg_p0    <= 3'd0;
            from_p0   <= 3'd1;
            tbl[0]    <= 8'h00;
            tbl[1]    <= 8'hFE;
            tbl[2]    <= 8'hA4;
            tbl[3]    <= 8'h5C;
            tbl[4]    <= 8'hB4;
            tbl[5]    <= 8'h62;
            tbl[6]    <= 8'h54;
            tbl[7]    <= 8'h54;
        end else begin
            if (sel_valid && sel_deg != 3'd0)
                cur_deg <= sel_deg;
            if (state == IDLE && tbl_we)
                tbl[tbl_addr] <= tbl_data;
            // Stage boundary: request latch; the scan sees only these copies.
            if (state == IDLE && recalculate) begin
                idx_p0  <= 2'd0;
                key_p0  <= key;
                from_p0 <= cur_deg;
                deg_p0  <= (key > 4'd11) ? 3'd0 : interval_degree(wrap12(diff));
            end
            // Stage boundary: one candidate slot retired per SCAN cycle.
            if (state == SCAN) begin
                for (int k = 0; k < NUM_CAND; k++) begin
                    if (idx_p0 == 2'(k)) begin
                        chords[16*k +: 16] <= cand_slot;
                        cand_mask[k]       <= cand_ok;
                    end
                end
                idx_p0 <= idx_p0 + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_chord_suggest_seq.sv
// Randomized bench for chord_suggest_seq: a cycle-level behavioural model is
// compared every cycle, with directed literal cases pinning the model.
module tb_chord_suggest_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        recalculate = 1'b0;
    logic [3:0]  key = 4'd0;
    logic [3:0]  note = 4'd0;
    logic        sel_valid = 1'b0;
    logic [2:0]  sel_deg = 3'd0;
    logic        tbl_we = 1'b0;
    logic [2:0]  tbl_addr = 3'd0;
    logic [7:0]  tbl_data = 8'd0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [63:0] chords;
    logic [3:0]  cand_mask;
    logic        busy;
    logic [2:0]  cur_deg;

    logic        recalc2 = 1'b0;
    logic [3:0]  key2 = 4'd0;
    logic [3:0]  note2 = 4'd0;
    logic        zero_bit = 1'b0;
    logic [2:0]  zero3 = 3'd0;
    logic [7:0]  zero8 = 8'd0;
    logic        out_ready2 = 1'b0;
    logic        out_valid2;
    logic [31:0] chords2;
    logic [1:0]  cand_mask2;
    logic        busy2;
    logic [2:0]  cur_deg2;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 1'b0;

    int          m_state = 0;
    int          m_cnt = 0;
    int          m_cur = 1;
    bit          m_fresh = 1'b1;
    logic [7:0]  m_tbl [8];
    logic [63:0] m_chords = '1;
    logic [3:0]  m_mask = '0;

    always #5 clk = ~clk;

    chord_suggest_seq dut (
        .clk(clk), .rst_n(rst_n), .recalculate(recalculate), .key(key), .note(note),
        .sel_valid(sel_valid), .sel_deg(sel_deg), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .out_ready(out_ready), .out_valid(out_valid), .chords(chords),
        .cand_mask(cand_mask), .busy(busy), .cur_deg(cur_deg)
    );

    chord_suggest_seq #(.NUM_CAND(2), .CHORD_NOTES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .recalculate(recalc2), .key(key2), .note(note2),
        .sel_valid(zero_bit), .sel_deg(zero3), .tbl_we(zero_bit), .tbl_addr(zero3),
        .tbl_data(zero8), .out_ready(out_ready2), .out_valid(out_valid2), .chords(chords2),
        .cand_mask(cand_mask2), .busy(busy2), .cur_deg(cur_deg2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Musical reference: find the scale degree of the note, then list the chords that contain it.
    function automatic void model_result(input int kk, input int nn, input logic [7:0] row,
                                         input int nc, input int nts,
                                         output logic [63:0] ch, output logic [3:0] mk);
        int ofs [7] = '{0, 2, 4, 5, 7, 9, 11};
        int d, c, pc, iv;
        logic [15:0] slot;
        ch = '1;
        mk = '0;
        d = 0;
        iv = (nn - kk + 24) % 12;
        if (kk < 12)
            for (int i = 0; i < 7; i++)
                if (ofs[i] == iv) d = i + 1;
        for (int k = 0; k < nc; k++) begin
            c = (((d - 1 - 2*k) % 7) + 7) % 7 + 1;
            if (d != 0 && row[c]) begin
                for (int j = 0; j < 4; j++) begin
                    pc = (kk + ofs[(c - 1 + 2*j) % 7]) % 12;
                    slot[4*(3-j) +: 4] = (j == 3 && nts == 3) ? 4'hF : 4'(pc);
                end
                ch[16*k +: 16] = slot;
                mk[k] = 1'b1;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = 0;
            m_cnt = 0;
            m_cur = 1;
            m_fresh = 1'b1;
            m_tbl = '{8'h00, 8'hFE, 8'hA4, 8'h5C, 8'hB4, 8'h62, 8'h54, 8'h54};
        end else begin
            case (m_state)
                0: begin
                    if (tbl_we) m_tbl[tbl_addr] = tbl_data;
                    if (recalculate) begin
                        model_result(int'(key), int'(note), m_tbl[m_cur], 4, 4, m_chords, m_mask);
                        m_state = 1;
                        m_cnt = 0;
                        m_fresh = 1'b0;
                    end
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == 4) m_state = 2;
                end
                default: if (out_ready) m_state = 0;
            endcase
            if (sel_valid && sel_deg != 3'd0) m_cur = int'(sel_deg);
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("busy", busy, m_state != 0);
            chk("out_valid", out_valid, m_state == 2);
            chk("cur_deg", cur_deg, 64'(m_cur));
            if (m_state == 2) begin
                chk("chords", chords, m_chords);
                chk("cand_mask", cand_mask, m_mask);
            end else if (m_fresh) begin
                chk("chords_after_reset", chords, '1);
                chk("mask_after_reset", cand_mask, 64'd0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_run(input int k, input int n);
        int lat;
        key = 4'(k);
        note = 4'(n);
        recalculate = 1'b1;
        tick();
        recalculate = 1'b0;
        lat = 1;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        chk("latency", lat - 1, 64'd4);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_after_ready", busy, 64'd0);
    endtask

    task automatic commit(input int d);
        sel_valid = 1'b1;
        sel_deg = 3'(d);
        tick();
        sel_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e_ch;
        logic [3:0]  e_mk;
        int cnt, hold, lat2, k, n;

        repeat (2) tick();
        rst_n = 1'b1;
        run_cmp = 1'b1;
        tick();
        chk("reset_chords", chords, '1);
        chk("reset_mask", cand_mask, 64'd0);
        chk("reset_cur_deg", cur_deg, 64'd1);
        chk("reset_busy", busy, 64'd0);

        start_run(0, 4);
        chk("c_major_E", chords, 64'h5904_9047_047B_47B2);
        chk("c_major_E_mask", cand_mask, 64'hF);
        for (int i = 0; i < 5; i++) begin
            recalculate = (i % 2 == 0);
            note = 4'(i + 5);
            tbl_we = 1'b1;
            tbl_addr = 3'd1;
            tbl_data = 8'h00;
            tick();
            chk("hold_valid", out_valid, 64'd1);
            chk("hold_chords", chords, 64'h5904_9047_047B_47B2);
        end
        tbl_we = 1'b0;
        recalculate = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        recalculate = 1'b0;
        chk("ready_wins_busy", busy, 64'd0);
        tick();
        chk("recalc_not_taken", busy, 64'd0);
        start_run(0, 4);
        chk("table_untouched", chords, 64'h5904_9047_047B_47B2);
        release_out();

        commit(5);
        start_run(0, 4);
        chk("from_V", chords, 64'hFFFF_9047_047B_FFFF);
        chk("from_V_mask", cand_mask, 64'h6);
        release_out();

        commit(0);
        chk("sel_zero_ignored", cur_deg, 64'd5);
        commit(1);
        start_run(2, 6);
        chk("d_major_Fs", chords[15:0], 64'h6914);
        release_out();
        start_run(0, 1);
        chk("chromatic", chords, '1);
        chk("chromatic_mask", cand_mask, 64'd0);
        release_out();

        commit(3);
        key = 4'd0;
        note = 4'd4;
        recalculate = 1'b1;
        tick();
        recalculate = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", busy, 64'd0);
        chk("abort_valid", out_valid, 64'd0);
        chk("abort_cur_deg", cur_deg, 64'd1);
        repeat (5) tick();
        chk("abort_no_output", out_valid, 64'd0);

        key2 = 4'd0;
        note2 = 4'd4;
        recalc2 = 1'b1;
        tick();
        recalc2 = 1'b0;
        lat2 = 1;
        while (!out_valid2 && lat2 < 30) begin
            tick();
            lat2++;
        end
        chk("small_latency", lat2 - 1, 64'd2);
        chk("small_chords", chords2, 64'h047F_47BF);
        chk("small_mask", cand_mask2, 64'h3);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            k = $urandom_range(0, 11);
            n = $urandom_range(0, 11);
            key2 = 4'(k);
            note2 = 4'(n);
            recalc2 = 1'b1;
            tick();
            recalc2 = 1'b0;
            cnt = 0;
            while (!out_valid2 && cnt < 20) begin
                tick();
                cnt++;
            end
            model_result(k, n, 8'hFE, 2, 3, e_ch, e_mk);
            chk("small_rand_chords", chords2, e_ch[31:0]);
            chk("small_rand_mask", cand_mask2, e_mk[1:0]);
            out_ready2 = 1'b1;
            tick();
            out_ready2 = 1'b0;
        end

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    tbl_addr = 3'($urandom_range(0, 7));
                    tbl_data = 8'($urandom);
                    tbl_we = 1'b1;
                    tick();
                    tbl_we = 1'b0;
                end
                1: commit($urandom_range(0, 7));
                default: begin
                    key = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15))
                                                      : 4'($urandom_range(0, 11));
                    note = 4'($urandom_range(0, 11));
                    recalculate = 1'b1;
                    tick();
                    cnt = 0;
                    while (!out_valid && cnt < 20) begin
                        recalculate = 1'($urandom);
                        key = 4'($urandom);
                        note = 4'($urandom_range(0, 11));
                        tbl_we = 1'($urandom);
                        tbl_addr = 3'($urandom);
                        tbl_data = 8'($urandom);
                        sel_valid = 1'($urandom);
                        sel_deg = 3'($urandom);
                        tick();
                        cnt++;
                    end
                    recalculate = 1'b0;
                    tbl_we = 1'b0;
                    sel_valid = 1'b0;
                    chk("rand_done", out_valid, 64'd1);
                    hold = $urandom_range(0, 3);
                    for (int h = 0; h < hold; h++) begin
                        recalculate = 1'($urandom);
                        tick();
                    end
                    out_ready = 1'b1;
                    recalculate = 1'($urandom);
                    tick();
                    out_ready = 1'b0;
                    recalculate = 1'b0;
                end
            endcase
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
